motor_step_ctrl: RTL and testbench



---
 rtl/motor_step_ctrl_if.sv | 19 +
 rtl/motor_step_ctrl.sv | 91 +++++++++
 tb/tb_motor_step_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/motor_step_ctrl_if.sv
// motor_step_ctrl_if: entry-stage commit inputs and motor driver outputs of motor_step_ctrl
//   master: drives Value/Motor/Lock, observes Step/Dir/Busy/Done/Reject/Pos
//   slave : the step controller
interface motor_step_ctrl_if #(
  parameter int NUM_MOTORS = 6,
  parameter int POS_W      = 10
);
  logic [POS_W-1:0]      Value;
  logic [2:0]            Motor;
  logic                  Lock;
  logic [NUM_MOTORS-1:0] Step;
  logic [NUM_MOTORS-1:0] Dir;
  logic                  Busy;
  logic                  Done;
  logic                  Reject;
  logic [POS_W-1:0]      Pos;
  modport master (output Value, Motor, Lock, input Step, Dir, Busy, Done, Reject, Pos);
  modport slave  (input Value, Motor, Lock, output Step, Dir, Busy, Done, Reject, Pos);
endinterface

// File: rtl/motor_step_ctrl.sv
// motor_step_ctrl: moves one of NUM_MOTORS stepper channels to a committed absolute target
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus.Value/Motor : target position and motor index, latched when Lock falls
//   bus.Step/Dir    : one-hot step pulses and per-motor direction (1 = increasing)
//   bus.Busy/Done   : move in progress / one-cycle completion pulse
//   bus.Reject      : one-cycle pulse for a commit that was discarded
//   bus.Pos         : tracked position of the motor currently selected by Motor
module motor_step_ctrl #(
  parameter int NUM_MOTORS = 6,
  parameter int POS_W      = 10,
  parameter int STEP_DIV   = 50000
) (
  input logic             clk,
  input logic             rst_n,
  motor_step_ctrl_if.slave bus
);
  localparam int CW = $clog2(STEP_DIV + 1);
  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, FIN} state_t;
  state_t           state;
  logic             lock_d;
  logic [POS_W-1:0] tgt;
  logic [2:0]       idx;
  logic [CW-1:0]    cnt;
  logic [POS_W-1:0] pos [NUM_MOTORS];
  logic             commit;
  logic             motor_ok;
  logic [POS_W-1:0] val_c;
  assign commit   = lock_d & ~bus.Lock;
  assign motor_ok = int'(bus.Motor) < NUM_MOTORS;
  assign val_c    = bus.Value > POS_W'(999) ? POS_W'(999) : bus.Value;
  assign bus.Pos  = motor_ok ? pos[bus.Motor] : '0;
  // HIGH is entered with cnt=0 from LOAD so the first Step edge trails Dir by one
  // cycle; re-entry from LOW raises Step on the transition with cnt=1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      lock_d     <= 1'b0;
      tgt        <= '0;
      idx        <= '0;
      cnt        <= '0;
      bus.Step   <= '0;
      bus.Dir    <= '0;
      bus.Busy   <= 1'b0;
      bus.Done   <= 1'b0;
      bus.Reject <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) pos[i] <= '0;
    end else begin
      lock_d     <= bus.Lock;
      bus.Reject <= commit & (bus.Busy | ~motor_ok);
      bus.Done   <= 1'b0;
      case (state)
        IDLE: if (commit && motor_ok) begin
          tgt      <= val_c;
          idx      <= bus.Motor;
          bus.Busy <= 1'b1;
          state    <= LOAD;
        end
        LOAD: if (pos[idx] == tgt) begin
          bus.Done <= 1'b1;
          state    <= FIN;
        end else begin
          bus.Dir[idx] <= tgt > pos[idx];
          cnt          <= '0;
          state        <= HIGH;
        end
        HIGH: if (cnt == '0) begin
          bus.Step[idx] <= 1'b1;
          cnt           <= CW'(1);
        end else if (cnt == CW'(STEP_DIV)) begin
          bus.Step[idx] <= 1'b0;
          pos[idx]      <= bus.Dir[idx] ? pos[idx] + 1'b1 : pos[idx] - 1'b1;
          cnt           <= CW'(1);
          state         <= LOW;
        end else cnt <= cnt + 1'b1;
        LOW: if (cnt != CW'(STEP_DIV)) cnt <= cnt + 1'b1;
        else if (pos[idx] == tgt) begin
          bus.Done <= 1'b1;
          state    <= FIN;
        end else begin
          bus.Step[idx] <= 1'b1;
          cnt           <= CW'(1);
          state         <= HIGH;
        end
        FIN: begin
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_motor_step_ctrl.sv
// tb_motor_step_ctrl: directed and randomized moves checked against a position/direction model
module tb_motor_step_ctrl;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int mpos [6];
  logic [5:0] mdir = '0;
  motor_step_ctrl_if #(.NUM_MOTORS(6), .POS_W(10)) bus();
  motor_step_ctrl #(.NUM_MOTORS(6), .POS_W(10), .STEP_DIV(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic commit(input int m, input int v);
    @(negedge clk);
    bus.Motor = 3'(m);
    bus.Value = 10'(v);
    bus.Lock  = 1'b1;
    @(negedge clk);
    bus.Lock  = 1'b0;
  endtask
  // inj = edge offset from the commit edge at which a second commit lands (0 = none);
  // offsets above 2 retarget that commit at motor 4 / value 5.
  task automatic move(input int m, input int v, input int inj);
    int vc, d, rises, busy_c, done_c, rej_c, first, done_j, run, bad_run, stray;
    logic lvl, dir1;
    logic [5:0] oh;
    vc = v > 999 ? 999 : v;
    d  = vc > mpos[m] ? vc - mpos[m] : mpos[m] - vc;
    if (d > 0) mdir[m] = vc > mpos[m];
    oh = 6'b1 << m;
    commit(m, v);
    rises = 0; busy_c = 0; done_c = 0; rej_c = 0; first = -1; done_j = -1;
    run = 0; bad_run = 0; stray = 0; lvl = 1'b0; dir1 = 1'b0;
    for (int j = 0; j < 3 + 2 * S * d + 10; j++) begin
      @(negedge clk);
      busy_c += int'(bus.Busy);
      done_c += int'(bus.Done);
      rej_c  += int'(bus.Reject);
      if (bus.Done && done_j < 0) done_j = j;
      if ((bus.Step & ~oh) != 0) stray++;
      if (j == 1) dir1 = bus.Dir[m];
      if (bus.Step[m] != lvl) begin
        if (bus.Step[m]) begin
          rises++;
          if (first < 0) first = j;
          else if (run != S) bad_run++;
        end else if (run != S) bad_run++;
        lvl = bus.Step[m];
        run = 1;
      end else run++;
      if (!bus.Busy) break;
      if (inj >= 2 && j == inj - 2) begin
        bus.Lock = 1'b1;
        if (inj > 2) begin
          bus.Motor = 3'd4;
          bus.Value = 10'd5;
        end
      end
      if (inj >= 2 && j == inj - 1) bus.Lock = 1'b0;
    end
    mpos[m] = vc;
    bus.Motor = 3'(m);
    bus.Value = 10'(v);
    #1;
    check("busy_cycles", busy_c, d == 0 ? 2 : 3 + 2 * S * d);
    check("step_pulses", rises, d);
    check("done_count", done_c, 1);
    check("done_cycle", done_j, d == 0 ? 1 : 2 + 2 * S * d);
    check("reject_count", rej_c, inj != 0 ? 1 : 0);
    check("stray_step", stray, 0);
    check("step_run_len", bad_run, 0);
    check("pos_after", bus.Pos, vc);
    check("dir_vector", bus.Dir, mdir);
    check("step_idle", bus.Step, 0);
    if (d > 0) begin
      check("first_step_cycle", first, 2);
      check("dir_at_load", dir1, mdir[m]);
    end
    if (inj > 2) begin
      bus.Motor = 3'd4;
      #1;
      check("pos4_untouched", bus.Pos, mpos[4]);
      bus.Motor = 3'(m);
    end
  endtask
  task automatic reject_invalid(input int m, input int v);
    int rej_c, busy_c;
    commit(m, v);
    rej_c = 0; busy_c = 0;
    repeat (4) begin
      @(negedge clk);
      rej_c  += int'(bus.Reject);
      busy_c += int'(bus.Busy);
    end
    check("bad_motor_reject", rej_c, 1);
    check("bad_motor_busy", busy_c, 0);
    check("bad_motor_pos", bus.Pos, 0);
  endtask
  initial begin
    int act;
    for (int i = 0; i < 6; i++) mpos[i] = 0;
    bus.Lock = 1'b0;
    bus.Motor = 3'd0;
    bus.Value = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_step", bus.Step, 0);
    check("rst_dir", bus.Dir, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_reject", bus.Reject, 0);
    check("rst_pos", bus.Pos, 0);
    rst_n = 1'b1;
    move(2, 3, 0);
    move(2, 1, 0);
    move(2, 1, 2);
    move(2, 4, 8);
    reject_invalid(6, 3);
    reject_invalid(7, 3);
    for (int r = 0; r < 12; r++) begin
      int m, v;
      m = int'($urandom_range(0, 5));
      v = ($urandom % 4 == 0) ? mpos[m] : int'($urandom_range(0, 30));
      move(m, v, 0);
    end
    move(0, 1023, 0);
    commit(1, mpos[1] + 5);
    repeat (4) @(negedge clk);
    check("pre_reset_step", bus.Step[1], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_step", bus.Step, 0);
    check("async_rst_dir", bus.Dir, 0);
    check("async_rst_busy", bus.Busy, 0);
    check("async_rst_pos", bus.Pos, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) mpos[i] = 0;
    mdir = '0;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act += int'(bus.Step != 0) + int'(bus.Busy) + int'(bus.Done);
    end
    check("post_reset_quiet", act, 0);
    move(3, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
